// File: rtl/exc_pkg.sv
// Shared definitions for the exception scheduler: ExcCodes, event flag
// positions, CP0 Status/Cause field positions, FSM states and the
// interrupt-pending helper.
package exc_pkg;

    // CP0 ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bit positions inside ex_flags_i
    localparam int FLAG_ADEL_IF = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_SYS     = 2;
    localparam int FLAG_BP      = 3;
    localparam int FLAG_OV      = 4;
    localparam int FLAG_ADEL_D  = 5;
    localparam int FLAG_ADES_D  = 6;
    localparam int FLAG_ERET    = 7;

    // CP0 Status / Cause field positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 9;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        FLUSH,
        REDIRECT
    } state_e;

    // Source of the BadVAddr value recorded with a commit
    typedef enum logic [1:0] {
        BVA_NONE,
        BVA_PC,
        BVA_DATA
    } bva_sel_e;

    // An interrupt is pending when interrupts are globally enabled, we are
    // not already at exception level, and some unmasked line is asserted.
    function automatic logic int_pending(input logic [31:0] status,
                                         input logic [31:0] cause,
                                         input logic [5:0]  hw_int);
        logic [7:0] lines;
        lines = {hw_int, cause[CAUSE_IP_HI:CAUSE_IP_LO]};
        return status[STATUS_IE] && !status[STATUS_EXL] &&
               (|(lines & status[STATUS_IM_HI:STATUS_IM_LO]));
    endfunction

endpackage

// File: rtl/exc_sched_if.sv
// MEM-stage / CP0 signal bundle for the exception scheduler. The master
// side is the pipeline + CP0 environment, the slave side is the scheduler.
interface exc_sched_if;

    // MEM-stage and CP0 state toward the scheduler
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_bd_i;
    logic [31:0] ex_badvaddr_i;
    logic [7:0]  ex_flags_i;
    logic [5:0]  hw_int_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] ebase_i;

    // Commit, flush and redirect back to CP0 and the pipeline
    logic        exc_req_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic [31:0] exc_badvaddr_o;
    logic        exc_bd_o;
    logic        eret_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    modport master (
        output ex_valid_i, ex_pc_i, ex_bd_i, ex_badvaddr_i, ex_flags_i,
               hw_int_i, status_i, cause_i, epc_i, ebase_i,
        input  exc_req_o, exc_code_o, exc_epc_o, exc_badvaddr_o, exc_bd_o,
               eret_o, flush_o, redirect_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_bd_i, ex_badvaddr_i, ex_flags_i,
               hw_int_i, status_i, cause_i, epc_i, ebase_i,
        output exc_req_o, exc_code_o, exc_epc_o, exc_badvaddr_o, exc_bd_o,
               eret_o, flush_o, redirect_o, redirect_pc_o, busy_o
    );

endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single highest-priority event
// among a pending interrupt and the MEM-stage flags.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [7:0] flags,
    input  logic       int_pend,
    output logic       valid,
    output logic [4:0] code,
    output logic       is_eret,
    output bva_sel_e   bva_sel
);

    // Fixed-priority select, interrupt first, ERET last
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        valid   = 1'b1;
        code    = EXC_INT;
        is_eret = 1'b0;
        bva_sel = BVA_NONE;
        if (int_pend) begin
            code = EXC_INT;
        end else if (flags[FLAG_ADEL_IF]) begin
            code    = EXC_ADEL;
            bva_sel = BVA_PC;
        end else if (flags[FLAG_RI]) begin
            code = EXC_RI;
        end else if (flags[FLAG_SYS]) begin
            code = EXC_SYS;
        end else if (flags[FLAG_BP]) begin
            code = EXC_BP;
        end else if (flags[FLAG_OV]) begin
            code = EXC_OV;
        end else if (flags[FLAG_ADEL_D]) begin
            code    = EXC_ADEL;
            bva_sel = BVA_DATA;
        end else if (flags[FLAG_ADES_D]) begin
            code    = EXC_ADES;
            bva_sel = BVA_DATA;
        end else if (flags[FLAG_ERET]) begin
            is_eret = 1'b1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler between MEM and CP0. Captures one event in
// IDLE, then sequences commit pulse -> flush window -> single redirect.
// FLUSH_CYCLES must lie in 1..15.
module exc_sched
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_OFFSET   = 32'h180
) (
    input logic        clk,
    input logic        rst,
    exc_sched_if.slave bus
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        int_pend;
    logic        enc_valid;
    logic [4:0]  enc_code;
    logic        enc_eret;
    bva_sel_e    enc_bva_sel;
    logic        capture;

    logic        is_eret_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic [31:0] bva_q;
    logic        bd_q;
    logic [31:0] target_q;
    logic [31:0] redirect_pc_q;

    logic        unused_fields;

    assign int_pend = int_pending(bus.status_i, bus.cause_i, bus.hw_int_i);

    // Status/Cause bits outside IE, EXL, IM and the software IP bits are
    // not relevant here.
    assign unused_fields = ^{bus.status_i[31:16], bus.status_i[7:2],
                             bus.cause_i[31:10], bus.cause_i[7:0]};

    exc_prio_enc u_prio_enc (
        .flags    (bus.ex_flags_i),
        .int_pend (int_pend),
        .valid    (enc_valid),
        .code     (enc_code),
        .is_eret  (enc_eret),
        .bva_sel  (enc_bva_sel)
    );

    // Inputs only matter in IDLE; anything arriving later is flushed anyway
    assign capture = (state_q == IDLE) && bus.ex_valid_i && enc_valid;

    // State and flush-counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt counts flush cycles already spent, COMMIT included
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (capture) state_d = COMMIT;
            end
            COMMIT: begin
                cnt_d   = 4'd1;
                state_d = (FLUSH_CYCLES == 1) ? REDIRECT : FLUSH;
            end
            FLUSH: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == FLUSH_LAST) state_d = REDIRECT;
            end
            REDIRECT: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Latch commit data and redirect target at capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data registers are reset too, so every output reads 0 while in reset.
            is_eret_q <= 1'b0;
            code_q    <= 5'd0;
            epc_q     <= 32'd0;
            bva_q     <= 32'd0;
            bd_q      <= 1'b0;
            target_q  <= 32'd0;
        end else if (capture) begin
            is_eret_q <= enc_eret;
            bd_q      <= bus.ex_bd_i;
            if (enc_eret) begin
                code_q   <= 5'd0;
                epc_q    <= 32'd0;
                bva_q    <= 32'd0;
                target_q <= bus.epc_i;
            end else begin
                code_q   <= enc_code;
                epc_q    <= bus.ex_bd_i ? (bus.ex_pc_i - 32'd4) : bus.ex_pc_i;
                target_q <= bus.ebase_i + VEC_OFFSET;
                unique case (enc_bva_sel)
                    BVA_PC:   bva_q <= bus.ex_pc_i;
                    BVA_DATA: bva_q <= bus.ex_badvaddr_i;
                    default:  bva_q <= 32'd0;
                endcase
            end
        end
    end

    // Redirect target only changes on entry to REDIRECT, then holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc_q <= 32'd0;
        end else if (state_d == REDIRECT && state_q != REDIRECT) begin
            redirect_pc_q <= target_q;
        end
    end

    // Outputs decoded from registered state only
    assign bus.exc_req_o      = (state_q == COMMIT) && !is_eret_q;
    assign bus.eret_o         = (state_q == COMMIT) &&  is_eret_q;
    assign bus.exc_code_o     = code_q;
    assign bus.exc_epc_o      = epc_q;
    assign bus.exc_badvaddr_o = bva_q;
    assign bus.exc_bd_o       = bd_q;
    assign bus.flush_o        = (state_q == COMMIT) || (state_q == FLUSH);
    assign bus.redirect_o     = (state_q == REDIRECT);
    assign bus.redirect_pc_o  = redirect_pc_q;
    assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: table of events run back-to-back,
// a commit scoreboard, plus hand sequences for ignored inputs and reset.
module tb_exc_sched;

    localparam int FC = 2;

    typedef struct {
        logic [7:0]  flags;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] addr;
        logic [5:0]  hw;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
        logic        x_eret;
        logic [4:0]  x_code;
        logic [31:0] x_epc;
        logic [31:0] x_bva;
        logic        x_bd;
        logic [31:0] x_tgt;
    } vec_t;

    typedef struct {
        logic        eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bva;
        logic        bd;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t vecs[13];

    exc_sched_if bus ();

    exc_sched #(.FLUSH_CYCLES(FC), .VEC_OFFSET(32'h180)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] f, input logic [31:0] pc, input logic bd,
                                input logic [31:0] addr, input logic [5:0] hw,
                                input logic [31:0] st, input logic [31:0] ca,
                                input logic [31:0] epc, input logic [31:0] eb,
                                input logic xe, input logic [4:0] xc, input logic [31:0] xepc,
                                input logic [31:0] xbva, input logic xbd, input logic [31:0] xt);
        vec_t v;
        v.flags = f;  v.pc = pc;  v.bd = bd;  v.addr = addr;  v.hw = hw;
        v.status = st;  v.cause = ca;  v.epc = epc;  v.ebase = eb;
        v.x_eret = xe;  v.x_code = xc;  v.x_epc = xepc;  v.x_bva = xbva;
        v.x_bd = xbd;  v.x_tgt = xt;
        return v;
    endfunction

    // Scoreboard: every commit/eret pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.exc_req_o === 1'b1 || bus.eret_o === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb.eret",    32'(bus.eret_o),    32'(e.eret));
                check("sb.exc_req", 32'(bus.exc_req_o), 32'(!e.eret));
                check("sb.code",    32'(bus.exc_code_o), 32'(e.code));
                check("sb.epc",     bus.exc_epc_o,      e.epc);
                check("sb.bva",     bus.exc_badvaddr_o, e.bva);
                check("sb.bd",      32'(bus.exc_bd_o),  32'(e.bd));
            end
        end
    end

    task automatic drive_idle();
        bus.ex_valid_i    = 1'b0;
        bus.ex_pc_i       = 32'd0;
        bus.ex_bd_i       = 1'b0;
        bus.ex_badvaddr_i = 32'd0;
        bus.ex_flags_i    = 8'd0;
        bus.hw_int_i      = 6'd0;
        bus.status_i      = 32'd0;
        bus.cause_i       = 32'd0;
        bus.epc_i         = 32'd0;
        bus.ebase_i       = 32'h8000_0000;
    endtask

    // Called at a negedge in IDLE; returns at the negedge where busy has fallen
    task automatic run_vec(input vec_t v, input bit noise, input string tag);
        exp_t e;
        bus.ex_valid_i    = 1'b1;
        bus.ex_flags_i    = v.flags;
        bus.ex_pc_i       = v.pc;
        bus.ex_bd_i       = v.bd;
        bus.ex_badvaddr_i = v.addr;
        bus.hw_int_i      = v.hw;
        bus.status_i      = v.status;
        bus.cause_i       = v.cause;
        bus.epc_i         = v.epc;
        bus.ebase_i       = v.ebase;
        e.eret = v.x_eret;  e.code = v.x_code;  e.epc = v.x_epc;
        e.bva = v.x_bva;    e.bd = v.x_bd;
        sb.push_back(e);

        @(negedge clk);
        check({tag, ".pulse"},    32'(bus.exc_req_o | bus.eret_o), 32'd1);
        check({tag, ".flush1"},   32'(bus.flush_o), 32'd1);
        check({tag, ".busy1"},    32'(bus.busy_o), 32'd1);
        check({tag, ".redir1"},   32'(bus.redirect_o), 32'd0);
        if (noise) begin
            bus.ex_valid_i = 1'b1;
            bus.ex_flags_i = 8'h08;
            bus.ex_pc_i    = 32'h9000_0000;
            bus.epc_i      = 32'h1111_1110;
            bus.ebase_i    = 32'h2222_0000;
        end else begin
            bus.ex_valid_i = 1'b0;
        end

        for (int k = 2; k <= FC; k++) begin
            @(negedge clk);
            check({tag, ".flushk"}, 32'(bus.flush_o), 32'd1);
            check({tag, ".nopulse"}, 32'(bus.exc_req_o | bus.eret_o), 32'd0);
        end

        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        check({tag, ".redir"},    32'(bus.redirect_o), 32'd1);
        check({tag, ".redir_pc"}, bus.redirect_pc_o, v.x_tgt);
        check({tag, ".flush_lo"}, 32'(bus.flush_o), 32'd0);
        check({tag, ".busy_r"},   32'(bus.busy_o), 32'd1);

        @(negedge clk);
        check({tag, ".busy_lo"},  32'(bus.busy_o), 32'd0);
        check({tag, ".redir_lo"}, 32'(bus.redirect_o), 32'd0);
        check({tag, ".pc_hold"},  bus.redirect_pc_o, v.x_tgt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},   32'(bus.exc_req_o), 32'd0);
        check({tag, ".eret"},  32'(bus.eret_o), 32'd0);
        check({tag, ".code"},  32'(bus.exc_code_o), 32'd0);
        check({tag, ".epc"},   bus.exc_epc_o, 32'd0);
        check({tag, ".bva"},   bus.exc_badvaddr_o, 32'd0);
        check({tag, ".bd"},    32'(bus.exc_bd_o), 32'd0);
        check({tag, ".flush"}, 32'(bus.flush_o), 32'd0);
        check({tag, ".redir"}, 32'(bus.redirect_o), 32'd0);
        check({tag, ".rpc"},   bus.redirect_pc_o, 32'd0);
        check({tag, ".busy"},  32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //          flags   pc            bd    addr          hw        status        cause         epc           ebase         eret  code   x_epc         x_bva         x_bd  target
        vecs[0]  = mk(8'h04, 32'h8000_0100, 1'b0, 32'h0,        6'h00,    32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd8,  32'h8000_0100, 32'h0,        1'b0, 32'h8000_0180);
        vecs[1]  = mk(8'h20, 32'h0000_2004, 1'b1, 32'h1234_5671, 6'h00,   32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd4,  32'h0000_2000, 32'h1234_5671, 1'b1, 32'h8000_0180);
        vecs[2]  = mk(8'h10, 32'h8000_0200, 1'b0, 32'h0,        6'b100000, 32'h0000_8001, 32'h0,       32'h0,        32'h8000_0000, 1'b0, 5'd0,  32'h8000_0200, 32'h0,        1'b0, 32'h8000_0180);
        vecs[3]  = mk(8'h80, 32'h8000_0500, 1'b0, 32'h0,        6'h00,    32'h0,        32'h0,        32'h8000_0400, 32'h8000_0000, 1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 32'h8000_0400);
        vecs[4]  = mk(8'h10, 32'h8000_0300, 1'b0, 32'h0,        6'b100000, 32'h0000_8003, 32'h0,       32'h0,        32'h8000_0000, 1'b0, 5'd12, 32'h8000_0300, 32'h0,        1'b0, 32'h8000_0180);
        vecs[5]  = mk(8'h0E, 32'h8000_0600, 1'b0, 32'h0,        6'h00,    32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd10, 32'h8000_0600, 32'h0,        1'b0, 32'h8000_0180);
        vecs[6]  = mk(8'h03, 32'hBFC0_0003, 1'b0, 32'h5555_0000, 6'h00,   32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd4,  32'hBFC0_0003, 32'hBFC0_0003, 1'b0, 32'h8000_0180);
        vecs[7]  = mk(8'h40, 32'h8000_0700, 1'b0, 32'hDEAD_BEEF, 6'h00,   32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd5,  32'h8000_0700, 32'hDEAD_BEEF, 1'b0, 32'h8000_0180);
        vecs[8]  = mk(8'h18, 32'h8000_0800, 1'b0, 32'h0,        6'h00,    32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd9,  32'h8000_0800, 32'h0,        1'b0, 32'h8000_0180);
        vecs[9]  = mk(8'h04, 32'h0000_0400, 1'b0, 32'h0,        6'h00,    32'h0,        32'h0,        32'h0,        32'hFFFF_FF00, 1'b0, 5'd8,  32'h0000_0400, 32'h0,        1'b0, 32'h0000_0080);
        vecs[10] = mk(8'h00, 32'h0000_0100, 1'b1, 32'h0,        6'h00,    32'h0000_0101, 32'h0000_0100, 32'h0,      32'h8000_0000, 1'b0, 5'd0,  32'h0000_00FC, 32'h0,        1'b1, 32'h8000_0180);
        vecs[11] = mk(8'h10, 32'h0000_0002, 1'b1, 32'h0,        6'h00,    32'h0,        32'h0,        32'h0,        32'h8000_0000, 1'b0, 5'd12, 32'hFFFF_FFFE, 32'h0,        1'b1, 32'h8000_0180);
        vecs[12] = mk(8'h60, 32'h8000_0900, 1'b0, 32'h0000_0ABC, 6'h00,   32'h0,        32'h0,        32'h0,        32'h8000_1000, 1'b0, 5'd4,  32'h8000_0900, 32'h0000_0ABC, 1'b0, 32'h8000_1180);

        // Reset state
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Table, back-to-back at the minimum spacing
        foreach (vecs[i]) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Second event offered during the whole sequence must be ignored
        run_vec(vecs[0], 1'b1, "ignore");
        repeat (3) begin
            @(negedge clk);
            check("ignore.idle", 32'(bus.busy_o), 32'd0);
        end

        // Pending interrupt lines with IE=0, and flags without valid: no capture
        drive_idle();
        bus.ex_valid_i = 1'b1;
        bus.hw_int_i   = 6'h3F;
        bus.status_i   = 32'h0000_FF00;
        repeat (3) begin
            @(negedge clk);
            check("no_event.busy", 32'(bus.busy_o), 32'd0);
        end
        bus.ex_valid_i = 1'b0;
        bus.ex_flags_i = 8'h04;
        repeat (2) begin
            @(negedge clk);
            check("no_valid.busy", 32'(bus.busy_o), 32'd0);
        end
        drive_idle();

        // Reset asserted mid-FLUSH aborts the sequence
        bus.ex_valid_i = 1'b1;
        bus.ex_flags_i = 8'h04;
        bus.ex_pc_i    = 32'h8000_0A00;
        sb.push_back('{1'b0, 5'd8, 32'h8000_0A00, 32'h0, 1'b0});
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        check("rst_mid.commit", 32'(bus.exc_req_o), 32'd1);
        @(negedge clk);
        check("rst_mid.flush", 32'(bus.flush_o), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_after.redir", 32'(bus.redirect_o), 32'd0);
            check("rst_after.busy",  32'(bus.busy_o), 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exc_sched.md
# exc_sched

Exception/interrupt scheduler sitting between the MEM stage and CP0. Each cycle it picks the highest-priority pending event (interrupt, synchronous exception or ERET) for the instruction in MEM. It then sequences the response: a one-cycle commit pulse into CP0's exception inputs, a flush window over the pipeline, and a single redirect to the handler vector or EPC.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush_o` is held; legal range 1..15.
- VEC_OFFSET, 32'h180: general exception vector offset added to EBase.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ex_valid_i  in  1  MEM-stage instruction is valid.
- ex_pc_i  in  32  PC of the MEM-stage instruction.
- ex_bd_i  in  1  MEM-stage instruction is in a branch delay slot.
- ex_badvaddr_i  in  32  faulting data address.
- ex_flags_i  in  8  event flags: [0] AdEL fetch, [1] RI, [2] Syscall, [3] Break, [4] Ov, [5] AdEL data, [6] AdES data, [7] ERET.
- hw_int_i  in  6  hardware interrupt lines (IP7..IP2).
- status_i  in  32  CP0 Status.
- cause_i  in  32  CP0 Cause.
- epc_i  in  32  CP0 EPC.
- ebase_i  in  32  CP0 EBase.
- exc_req_o  out  1  one-cycle commit pulse to CP0.
- exc_code_o  out  5  ExcCode for the commit.
- exc_epc_o  out  32  EPC value for the commit.
- exc_badvaddr_o  out  32  BadVAddr value for the commit.
- exc_bd_o  out  1  Cause.BD value for the commit.
- eret_o  out  1  one-cycle pulse: CP0 clears Status.EXL.
- flush_o  out  1  kill all pipeline stages.
- redirect_o  out  1  one-cycle PC redirect strobe.
- redirect_pc_o  out  32  redirect target.
- busy_o  out  1  high whenever the scheduler is not in IDLE.

## Operation
- Interrupt pending is `int_pend`. It is high when all three hold:
  - Status.IE (bit 0) is set;
  - Status.EXL (bit 1) is clear;
  - `{hw_int_i, cause_i[9:8]} & status_i[15:8]` is non-zero.
- Event taken only in IDLE with `ex_valid_i=1`.
- Priority, highest first:
  - `int_pend`: code 0;
  - AdEL fetch: code 4;
  - RI: code 10;
  - Syscall: code 8;
  - Break: code 9;
  - Ov: code 12;
  - AdEL data: code 4;
  - AdES data: code 5;
  - ERET.
- Lower-priority flags are ignored when a higher one fires.
- EPC: `ex_bd_i ? ex_pc_i-4 : ex_pc_i` (mod 2^32); `exc_bd_o=ex_bd_i`.
- BadVAddr:
  - AdEL fetch: `ex_pc_i`;
  - AdEL/AdES data: `ex_badvaddr_i`;
  - otherwise: 0.
- Target:
  - ERET: `epc_i`, sampled at capture;
  - otherwise: `ebase_i + VEC_OFFSET`, 32-bit wrap, sampled at capture.
- ERET: `eret_o` pulses instead of `exc_req_o`; `exc_code_o`, `exc_epc_o` and `exc_badvaddr_o` are 0.
- FSM states and transitions:
  - IDLE → COMMIT on capture.
  - COMMIT → FLUSH after 1 cycle.
  - FLUSH → REDIRECT after FLUSH_CYCLES cycles.
  - REDIRECT → IDLE after 1 cycle.
- All inputs are ignored outside IDLE; events arriving then are flushed and re-occur on refetch.

## Timing
- Reset: every output 0, FSM in IDLE, flush counter 0. Reset asserted mid-sequence aborts immediately; no further pulses are emitted.
- Capture at edge T.
- Cycle T+1 (COMMIT):
  - `exc_req_o` or `eret_o` high for exactly one cycle;
  - code, EPC, BadVAddr and BD outputs valid that same cycle;
  - `flush_o` rises;
  - `busy_o` rises.
- `flush_o` stays high for cycles T+1 .. T+FLUSH_CYCLES.
- Cycle T+FLUSH_CYCLES+1 (REDIRECT):
  - `redirect_o` is high for one cycle with `redirect_pc_o` valid;
  - `flush_o` is low;
  - `busy_o` is still high.
- `busy_o` falls at T+FLUSH_CYCLES+2. A new capture is possible on that edge, so back-to-back events are spaced FLUSH_CYCLES+2 cycles apart.
- Outside pulse cycles, data outputs hold their last values and `redirect_pc_o` holds. Data outputs are registered; none are combinational from inputs.
- Interrupt and exception in the same cycle: the interrupt wins and EPC is the instruction's own PC.

## Structure
- Package `exc_pkg` holds:
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - flag bit indices;
  - the state enum {IDLE, COMMIT, FLUSH, REDIRECT};
  - the Status and Cause field positions.
- Sub-module `exc_prio_enc`: combinational priority encoder taking flags and `int_pend` and returning valid, code, is_eret and badvaddr-select.

## Test plan
- Syscall at PC 0x8000_0100, not in a delay slot, EBase 0x8000_0000:
  - T+1: `exc_req_o=1`, code 8, EPC 0x8000_0100;
  - flush high for 2 cycles;
  - T+3: redirect to 0x8000_0180.
- AdEL data in a delay slot, PC 0x0000_2004, addr 0x1234_5671:
  - code 4, EPC 0x0000_2000, BD=1, BadVAddr 0x1234_5671.
- `hw_int_i[5]=1`, IM7 set, IE=1, EXL=0, together with the Ov flag:
  - code 0 (interrupt wins), EPC = `ex_pc_i`.
- ERET with `epc_i`=0x8000_0400:
  - `eret_o` pulses and `exc_req_o` stays 0;
  - redirect to 0x8000_0400.
- Second event during FLUSH is ignored. Same event with EXL=1 and a pending interrupt yields no interrupt commit.
- `rst` low mid-FLUSH: all outputs 0 asynchronously; after release no redirect occurs and `busy_o=0`.
